// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter (SRL/SLL/SRA/ROR): one registered mux level per shift-amount bit, valid/ready on both sides.
// Optional macro SHIFT_OVF_EN widens in_amt by one bit and adds a leading stage for amounts of WIDTH or more.
module pipelined_barrel_shifter #(
    parameter int WIDTH = 16,
    localparam int SHW = $clog2(WIDTH),
`ifdef SHIFT_OVF_EN
    localparam int AW = SHW + 1
`else
    localparam int AW = SHW
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AW-1:0]    in_amt,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_carry,
    output logic             out_zero
);
    localparam int STAGES = AW;
    localparam logic [1:0] OP_SRL = 2'b00;
    localparam logic [1:0] OP_SLL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
    localparam logic [AW-1:0] AMT_ONE = AW'(1);

    // Stage registers; index k is the register at the output of stage k.
    logic [STAGES-1:0] vld;
    logic [STAGES-1:0] cry;
    logic [WIDTH-1:0]  dat [STAGES];
    logic [1:0]        op  [STAGES];
    logic [AW-1:0]     amt [STAGES];

    logic [STAGES-1:0] adv;
    logic [STAGES-1:0] src_vld;
    logic [STAGES-1:0] src_cry;
    logic [WIDTH-1:0]  src_dat [STAGES];
    logic [1:0]        src_op  [STAGES];
    logic [AW-1:0]     src_amt [STAGES];
    logic [STAGES-1:0] nxt_cry;
    logic [WIDTH-1:0]  nxt_dat [STAGES];

    // One mux level shifting by n; returns {carry, data}. A shift by WIDTH
    // (overflow stage) falls out naturally: zeros, all-sign, or identity for ROR.
    function automatic logic [WIDTH:0] shift_step(input logic [WIDTH-1:0] d,
                                                   input logic [1:0]       opc,
                                                   input int               n);
        logic signed [WIDTH-1:0] sd;
        logic [WIDTH-1:0]        r;
        logic                    c;
        sd = d;
        case (opc)
            OP_SRL: begin
                r = d >> n;
                c = |((d >> (n - 1)) & ONE);
            end
            OP_SLL: begin
                r = d << n;
                c = |((d >> (WIDTH - n)) & ONE);
            end
            OP_SRA: begin
                r = sd >>> n;
                c = |((d >> (n - 1)) & ONE);
            end
            default: begin
                r = (d >> n) | (d << (WIDTH - n));
                c = 1'b0;
            end
        endcase
        return {c, r};
    endfunction

    always_comb begin
        src_vld[0] = in_valid;
        src_dat[0] = in_data;
        src_op[0]  = in_op;
        src_amt[0] = in_amt;
        src_cry[0] = 1'b0;
        for (int k = 1; k < STAGES; k++) begin
            src_vld[k] = vld[k-1];
            src_dat[k] = dat[k-1];
            src_op[k]  = op[k-1];
            src_amt[k] = amt[k-1];
            src_cry[k] = cry[k-1];
        end
    end

    // Stage k consumes amount bit STAGES-1-k, so the largest shift goes first.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            if (((src_amt[k] >> (STAGES - 1 - k)) & AMT_ONE) != '0) begin
                {nxt_cry[k], nxt_dat[k]} = shift_step(src_dat[k], src_op[k], 1 << (STAGES - 1 - k));
            end else begin
                nxt_cry[k] = src_cry[k];
                nxt_dat[k] = src_dat[k];
            end
        end
    end

    // A stage may load when it is empty or everything downstream of it moves.
    always_comb begin
        logic go;
        go = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            go     = go || !vld[k];
            adv[k] = go;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
            cry <= '0;
            for (int k = 0; k < STAGES; k++) begin
                dat[k] <= '0;
                op[k]  <= '0;
                amt[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (adv[k]) begin
                    vld[k] <= src_vld[k];
                    if (src_vld[k]) begin
                        dat[k] <= nxt_dat[k];
                        cry[k] <= nxt_cry[k];
                        op[k]  <= src_op[k];
                        amt[k] <= src_amt[k];
                    end
                end
            end
        end
    end

    assign in_ready  = adv[0];
    assign out_valid = vld[STAGES-1];
    assign out_data  = dat[STAGES-1];
    assign out_zero  = (dat[STAGES-1] == '0);
    // Rotate carry is the final MSB whenever the request rotated at all.
    assign out_carry = (op[STAGES-1] == OP_ROR)
                     ? ((amt[STAGES-1] != '0) && dat[STAGES-1][WIDTH-1])
                     : cry[STAGES-1];

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Self-checking bench for pipelined_barrel_shifter: directed cases, stall/drain,
// asynchronous reset mid-flight, and random traffic against an arithmetic reference model.
module tb_pipelined_barrel_shifter;
    localparam int W = 16;
`ifdef SHIFT_OVF_EN
    localparam int AW  = 5;
    localparam int LAT = 5;
`else
    localparam int AW  = 4;
    localparam int LAT = 4;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic [AW-1:0] in_amt;
    logic [1:0]    in_op;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          out_carry;
    logic          out_zero;

    int vectors = 0;
    int miscompares = 0;
    logic [W:0] exp_q[$];
    bit acc;
    bit got;
    int n_got;

    pipelined_barrel_shifter #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_amt(in_amt), .in_op(in_op),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_carry(out_carry), .out_zero(out_zero)
    );

    always #5 clk = ~clk;

    // Reference: total shift computed directly on 64-bit integers.
    function automatic logic [W:0] model(input logic [W-1:0] d, input int a, input logic [1:0] o);
        longint u, s, r;
        logic   c;
        int     k;
        u = longint'(d);
        s = d[W-1] ? u - (longint'(1) << W) : u;
        r = u;
        c = 1'b0;
        case (o)
            2'b00: begin r = u >> a;  if (a != 0) c = ((u >> (a - 1)) & longint'(1)) != 0; end
            2'b01: begin r = u << a;  if (a != 0) c = (((u << a) >> W) & longint'(1)) != 0; end
            2'b10: begin r = s >>> a; if (a != 0) c = ((s >>> (a - 1)) & longint'(1)) != 0; end
            default: begin
                k = a % W;
                r = (u >> k) | (u << (W - k));
                if (a != 0) c = ((r >> (W - 1)) & longint'(1)) != 0;
            end
        endcase
        return {c, r[W-1:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic load_random();
        in_data = W'($urandom);
        in_amt  = AW'($urandom);
        in_op   = 2'($urandom);
    endtask

    // Called at a falling edge with inputs already driven; observes the
    // handshakes of the coming rising edge and returns at the next falling edge.
    task automatic tick();
        logic [W:0] e;
        #1;
        acc = in_valid && in_ready;
        got = out_valid && out_ready;
        if (acc) exp_q.push_back(model(in_data, int'(in_amt), in_op));
        if (got) begin
            if (exp_q.size() == 0) begin
                check("unrequested_out", 32'(out_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("stream_data", 32'(out_data), 32'(e[W-1:0]));
                check("stream_carry", 32'(out_carry), 32'(e[W]));
                check("stream_zero", 32'(out_zero), 32'(e[W-1:0] == '0));
                n_got++;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // Single request into an empty pipe; checks latency and result.
    task automatic run_one(input string tag, input logic [W-1:0] d, input int a, input logic [1:0] o,
                           input logic [W-1:0] ed, input logic ec);
        int edges;
        in_valid = 1'b1; in_data = d; in_amt = AW'(a); in_op = o; out_ready = 1'b1;
        #1;
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        in_valid = 1'b0;
        load_random();
        #1;
        while (!out_valid && edges < 3 * LAT) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            #1;
        end
        check({tag, "_latency"}, 32'(edges), 32'(LAT));
        check({tag, "_data"}, 32'(out_data), 32'(ed));
        check({tag, "_carry"}, 32'(out_carry), 32'(ec));
        check({tag, "_zero"}, 32'(out_zero), 32'(ed == '0));
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int sent, first, last;
        logic [W:0] held;

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_amt = '0; in_op = '0; out_ready = 1'b0;
        @(negedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_carry", 32'(out_carry), 32'd0);
        check("rst_out_zero", 32'(out_zero), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        run_one("srl_f0f0_4", 16'hF0F0, 4, 2'b00, 16'h0F0F, 1'b0);
        run_one("sra_8001_1", 16'h8001, 1, 2'b10, 16'hC000, 1'b1);
        run_one("sll_8001_15", 16'h8001, 15, 2'b01, 16'h8000, 1'b0);
        run_one("srl_0001_1", 16'h0001, 1, 2'b00, 16'h0000, 1'b1);
        run_one("ror_0001_1", 16'h0001, 1, 2'b11, 16'h8000, 1'b1);
        run_one("ror_1234_0", 16'h1234, 0, 2'b11, 16'h1234, 1'b0);
        run_one("sra_7ff0_15", 16'h7FF0, 15, 2'b10, 16'h0000, 1'b1);
`ifdef SHIFT_OVF_EN
        run_one("sra_8000_16", 16'h8000, 16, 2'b10, 16'hFFFF, 1'b1);
        run_one("srl_ffff_20", 16'hFFFF, 20, 2'b00, 16'h0000, 1'b0);
        run_one("ror_0001_17", 16'h0001, 17, 2'b11, 16'h8000, 1'b1);
        run_one("sll_0001_16", 16'h0001, 16, 2'b01, 16'h0000, 1'b1);
`endif

        // Back-to-back requests into a blocked output.
        out_ready = 1'b0; sent = 0; n_got = 0;
        in_valid = 1'b1; load_random();
        for (int cyc = 0; cyc < 3 * LAT; cyc++) begin
            tick();
            if (acc) begin sent++; load_random(); end
        end
        check("stall_accepts", 32'(sent), 32'(LAT));
        held = exp_q[0];
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_in_ready", 32'(in_ready), 32'd0);
            check("stall_out_valid", 32'(out_valid), 32'd1);
            check("stall_data_held", 32'(out_data), 32'(held[W-1:0]));
            check("stall_carry_held", 32'(out_carry), 32'(held[W]));
            @(posedge clk);
            @(negedge clk);
        end
        out_ready = 1'b1; first = -1; last = -1;
        for (int cyc = 0; cyc < 40 && n_got < 6; cyc++) begin
            in_valid = (sent < 6);
            tick();
            if (got) begin
                if (first < 0) first = cyc;
                last = cyc;
            end
            if (acc) begin sent++; load_random(); end
        end
        in_valid = 1'b0;
        check("drain_count", 32'(n_got), 32'd6);
        check("drain_consecutive", 32'(last - first), 32'd5);
        check("drain_queue_empty", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset with two requests in flight.
        in_valid = 1'b1; load_random();
        tick();
        load_random();
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < LAT - 2; i++) tick();
        #1;
        check("prereset_out_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midreset_out_valid", 32'(out_valid), 32'd0);
        check("midreset_in_ready", 32'(in_ready), 32'd1);
        check("midreset_out_zero", 32'(out_zero), 32'd1);
        #2;
        rst_n = 1'b1;
        exp_q.delete();
        @(negedge clk);
        for (int i = 0; i < 2 * LAT; i++) tick();
        #1;
        check("postreset_idle", 32'(out_valid), 32'd0);
        run_one("postreset_sll", 16'h00F1, 3, 2'b01, 16'h0788, 1'b0);

        // Random traffic with random backpressure.
        in_valid = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!in_valid) begin
                in_valid = ($urandom_range(0, 3) != 0);
                load_random();
            end
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
            if (acc) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4 * LAT && exp_q.size() != 0; i++) tick();
        check("random_drain_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
